multi_op_stream: RTL

Parametrised, pipelined successor to the team's combinational 8-bit multi-operation unit. Applies one of eight unary operations to each operand on a valid/ready input stream and returns the result with carry and zero flags on a valid/ready output stream. Two register stages; full throughput; backpressure-safe. Sits between an operand source (e.g. a stimulus FIFO) and a result consumer in the datapath.

---
 rtl/multi_op_pkg.sv | 18 +
 rtl/multi_op_alu.sv | 55 +++++
 rtl/multi_op_stream.sv | 81 ++++++++
 3 files changed

// File: rtl/multi_op_pkg.sv
// Shared types and default sizes for the multi_op_stream datapath.
package multi_op_pkg;

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_DEC  = 3'd1,
    OP_NOT  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/multi_op_alu.sv
// Combinational unary op unit: (data, op) -> (result, carry); zero latency, no flow control.
// Optional macro SATURATE_EN clamps inc of all-ones and dec of zero instead of wrapping.
module multi_op_alu
  import multi_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit of each extended sum is the carry-out / borrow.
  assign sum  = {1'b0, data} + {{WIDTH{1'b0}}, 1'b1};
  assign diff = {1'b0, data} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = data;
    carry  = 1'b0;
    case (op_e'(op))
      OP_INC: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
`ifdef SATURATE_EN
        if (sum[WIDTH]) result = {WIDTH{1'b1}};
`endif
      end
      OP_DEC: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
`ifdef SATURATE_EN
        if (diff[WIDTH]) result = {WIDTH{1'b0}};
`endif
      end
      OP_NOT: result = ~data;
      OP_SHL: begin
        result = {data[WIDTH-2:0], 1'b0};
        carry  = data[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, data[WIDTH-1:1]};
        carry  = data[0];
      end
      OP_ROL:  result = {data[WIDTH-2:0], data[WIDTH-1]};
      OP_ROR:  result = {data[0], data[WIDTH-1:1]};
      OP_PASS: result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/multi_op_stream.sv
// Two-stage valid/ready pipeline applying a unary op per operand; latency 2, one result per cycle.
// S2 holds while out_ready is low; in_ready follows out_ready combinationally. SATURATE_EN lives in multi_op_alu.
module multi_op_stream
  import multi_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [2:0]       s1_op;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  multi_op_alu #(.WIDTH(WIDTH)) u_alu (
    .data   (s1_data),
    .op     (s1_op),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_op    <= in_op;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Result and flags only move on s2_load, so they stay frozen through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= alu_result;
      out_carry <= alu_carry;
      out_zero  <= (alu_result == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s1_load) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
